pattern_gen_param: RTL and testbench

PATTERN_GEN_PARAM -- requirements
Module: pattern_gen_param

---
 rtl/pattern_gen_param.sv | 130 +++++++++++++
 tb/tb_pattern_gen_param.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pattern_gen_param                                          |
// | Description : Prescaled pattern generator. Every DIV enabled clocks one  |
// |               pattern step is taken: count up, count down, rotate left   |
// |               or one-hot bounce. port_B counts completed pattern periods.|
// | Ports       : clk      - clock, rising edge                              |
// |               reset    - asynchronous reset, active low                  |
// |               en       - run enable (0 freezes all state)                |
// |               mode     - 00 up, 01 down, 10 rotate left, 11 bounce       |
// |               load     - synchronous load strobe (wins over a step)      |
// |               load_val - value loaded into port_A                        |
// |               port_A   - current pattern (registered)                    |
// |               port_B   - pattern-period counter (registered)             |
// |               tick     - one-cycle pulse following each step             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pattern_gen_param #(
   parameter int WIDTH = 8,
   parameter int DIV   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] port_A,
   output logic [WIDTH-1:0] port_B,
   output logic             tick
);

   // A prescaler of at least one bit keeps DIV=1 legal; it then never leaves 0.
   localparam int             PW           = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]  c_PRESC_LAST = PW'(DIV - 1);
   localparam logic [WIDTH-1:0] c_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] c_ALL_ONES = {WIDTH{1'b1}};
   localparam logic           c_DIR_LEFT   = 1'b0;
   localparam logic           c_DIR_RIGHT  = 1'b1;

   localparam logic [1:0]     c_MODE_UP    = 2'b00;
   localparam logic [1:0]     c_MODE_DOWN  = 2'b01;
   localparam logic [1:0]     c_MODE_ROTL  = 2'b10;

   logic [PW-1:0]    r_presc;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_tick;
   logic             r_dir;

   logic             w_step;
   logic             w_onehot;

   assign w_step   = en && (r_presc == c_PRESC_LAST);
   // x & (x-1) clears the lowest set bit; zero result on a non-zero x means one-hot.
   assign w_onehot = (r_a != '0) && ((r_a & (r_a - c_ONE)) == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_presc <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_tick  <= 1'b0;
         r_dir   <= c_DIR_LEFT;
      end else if (load) begin
         r_a     <= load_val;
         r_presc <= '0;
         r_dir   <= c_DIR_LEFT;
         r_tick  <= 1'b0;
      end else if (en) begin
         r_presc <= w_step ? '0 : r_presc + 1'b1;
         r_tick  <= w_step;
         if (w_step) begin
            case (mode)
               c_MODE_UP: begin
                  r_a <= r_a + c_ONE;
                  if (r_a == c_ALL_ONES) r_b <= r_b + c_ONE;
               end
               c_MODE_DOWN: begin
                  r_a <= r_a - c_ONE;
                  if (r_a == '0) r_b <= r_b + c_ONE;
               end
               c_MODE_ROTL: begin
                  if (r_a == '0) begin
                     r_a <= c_ONE;
                  end else begin
                     r_a <= {r_a[WIDTH-2:0], r_a[WIDTH-1]};
                     if (r_a[WIDTH-1]) r_b <= r_b + c_ONE;
                  end
               end
               default: begin
                  if (!w_onehot) begin
                     r_a   <= c_ONE;
                     r_dir <= c_DIR_LEFT;
                  end else if (r_dir == c_DIR_LEFT) begin
                     if (r_a[WIDTH-1]) begin
                        // Loaded directly at the MSB while heading left: turn around.
                        r_a   <= r_a >> 1;
                        r_dir <= c_DIR_RIGHT;
                     end else begin
                        r_a <= r_a << 1;
                        if (r_a[WIDTH-2]) r_dir <= c_DIR_RIGHT;
                     end
                  end else begin
                     if (r_a[0]) begin
                        r_a   <= r_a << 1;
                        r_dir <= c_DIR_LEFT;
                     end else begin
                        r_a <= r_a >> 1;
                        // Arriving at bit 0 closes one full bounce period.
                        if (r_a[1]) begin
                           r_dir <= c_DIR_LEFT;
                           r_b   <= r_b + c_ONE;
                        end
                     end
                  end
               end
            endcase
         end
      end else begin
         r_tick <= 1'b0;
      end
   end

   assign port_A = r_a;
   assign port_B = r_b;
   assign tick   = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_pattern_gen_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pattern_gen_param                                       |
// | Description : Directed self-checking bench for pattern_gen_param with    |
// |               WIDTH=8, DIV=4. Expected outputs are queued as stimulus is |
// |               applied and popped for comparison after each clock edge.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pattern_gen_param;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [1:0] mode;
   logic       load;
   logic [7:0] load_val;
   logic [7:0] port_A;
   logic [7:0] port_B;
   logic       tick;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       t;
      string      tag;
   } exp_t;

   exp_t sb[$];

   pattern_gen_param #(.WIDTH(8), .DIV(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .mode     (mode),
      .load     (load),
      .load_val (load_val),
      .port_A   (port_A),
      .port_B   (port_B),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   task automatic push_exp(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic t);
      exp_t e;
      e.a = a; e.b = b; e.t = t; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      e = sb.pop_front();
      total++;
      assert ({port_A, port_B, tick} === {e.a, e.b, e.t})
      else begin
         bad++;
         $error("FAIL %s: got A=%h B=%h tick=%b, want A=%h B=%h tick=%b",
                e.tag, port_A, port_B, tick, e.a, e.b, e.t);
      end
   endtask

   // Expect a result without clocking (used for asynchronous reset checks).
   task automatic check_now(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic t);
      push_exp(tag, a, b, t);
      pop_check();
   endtask

   // One rising edge, then compare 1 time unit later.
   task automatic edge_chk(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic t);
      push_exp(tag, a, b, t);
      @(posedge clk);
      #1;
      pop_check();
   endtask

   // One full DIV=4 period with en=1: three quiet edges then the step edge.
   task automatic run_step(input string tag, input logic [7:0] pa, input logic [7:0] pb,
                           input logic [7:0] na, input logic [7:0] nb);
      for (int k = 0; k < 3; k++) edge_chk(tag, pa, pb, 1'b0);
      edge_chk(tag, na, nb, 1'b1);
   endtask

   logic [7:0] a_prev;
   logic [7:0] a_next;
   logic [7:0] b_cur;

   initial begin
      reset = 1'b0; en = 1'b0; mode = 2'b00; load = 1'b0; load_val = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_now("reset_state", 8'h00, 8'h00, 1'b0);

      // Count up from reset: step on every 4th enabled edge.
      reset = 1'b1; en = 1'b1; mode = 2'b00;
      for (int e = 1; e <= 12; e++)
         edge_chk("count_up", 8'(e / 4), 8'h00, (e % 4) == 0);

      // Load FF then wrap to 00, incrementing port_B.
      load = 1'b1; load_val = 8'hFF;
      edge_chk("load_ff", 8'hFF, 8'h00, 1'b0);
      load = 1'b0;
      run_step("up_wrap", 8'hFF, 8'h00, 8'h00, 8'h01);

      // Load on what would have been a step edge: load wins, period restarts.
      for (int k = 0; k < 3; k++) edge_chk("pre_load", 8'h00, 8'h01, 1'b0);
      load = 1'b1; load_val = 8'h10;
      edge_chk("load_prio", 8'h10, 8'h01, 1'b0);
      load = 1'b0;
      run_step("after_load", 8'h10, 8'h01, 8'h11, 8'h01);

      // Asynchronous reset between edges, then count down and rotate.
      #2 reset = 1'b0;
      #1 check_now("async_rst", 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      reset = 1'b1; mode = 2'b01;
      run_step("down_wrap", 8'h00, 8'h00, 8'hFF, 8'h01);
      mode = 2'b10;
      run_step("rotl_msb", 8'hFF, 8'h01, 8'hFF, 8'h02);

      // Rotate of zero seeds 1 without counting a period.
      load = 1'b1; load_val = 8'h00;
      edge_chk("load_00", 8'h00, 8'h02, 1'b0);
      load = 1'b0;
      run_step("rotl_zero", 8'h00, 8'h02, 8'h01, 8'h02);
      run_step("rotl_shift", 8'h01, 8'h02, 8'h02, 8'h02);

      // One-hot bounce: 14 steps, port_B counts only on the return to bit 0.
      mode = 2'b11; load = 1'b1; load_val = 8'h01;
      edge_chk("load_01", 8'h01, 8'h02, 1'b0);
      load = 1'b0;
      a_prev = 8'h01;
      b_cur  = 8'h02;
      for (int i = 1; i <= 14; i++) begin
         a_next = (i <= 7) ? (8'h01 << i) : (8'h01 << (14 - i));
         run_step("bounce", a_prev, b_cur, a_next, (i == 14) ? b_cur + 8'h01 : b_cur);
         a_prev = a_next;
      end
      b_cur = 8'h03;
      load = 1'b1; load_val = 8'h03;
      edge_chk("load_03", 8'h03, b_cur, 1'b0);
      load = 1'b0;
      run_step("bounce_fix", 8'h03, b_cur, 8'h01, b_cur);

      // Freeze mid-period with en=0; the prescaler must resume where it stopped.
      edge_chk("pre_freeze", 8'h01, b_cur, 1'b0);
      edge_chk("pre_freeze", 8'h01, b_cur, 1'b0);
      en = 1'b0;
      for (int k = 0; k < 10; k++) edge_chk("freeze", 8'h01, b_cur, 1'b0);
      en = 1'b1;
      edge_chk("resume", 8'h01, b_cur, 1'b0);
      edge_chk("resume_step", 8'h02, b_cur, 1'b1);

      // Load works while disabled.
      en = 1'b0; load = 1'b1; load_val = 8'h5A;
      edge_chk("load_dis", 8'h5A, b_cur, 1'b0);
      load = 1'b0;
      edge_chk("hold_dis", 8'h5A, b_cur, 1'b0);

      // Reset mid-period: progress discarded, first tick 4 enabled edges later.
      mode = 2'b00; en = 1'b1;
      edge_chk("pre_rst", 8'h5A, b_cur, 1'b0);
      edge_chk("pre_rst", 8'h5A, b_cur, 1'b0);
      #2 reset = 1'b0;
      #1 check_now("mid_rst", 8'h00, 8'h00, 1'b0);
      edge_chk("rst_held", 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      run_step("post_rst", 8'h00, 8'h00, 8'h01, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
